alu_mc: RTL and testbench

Multi-cycle, width-parametrised ALU that replaces the single-cycle combinational ALU in the EX stage when wider datapaths or full-width products are needed. It accepts one operation per start pulse and returns a registered result with a done pulse. Single-cycle ops (add/sub/and/or/xor) complete in one cycle. MUL uses an iterative shift-add unit that yields the full 2×WIDTH product. An optional restoring divider is compiled in by macro. The hazard unit stalls the pipeline on `busy_o`.

---
 rtl/alu_mc.sv | 187 ++++++++++++++++++
 tb/tb_alu_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. ADD/SUB/AND/OR/XOR complete in one cycle; MUL is an
// iterative shift-add giving the full 2*WIDTH product on {hi_o,data_o}.
// Define ALU_DIV_EN to add the restoring unsigned divider (opcode 1000):
// quotient on data_o, remainder on hi_o.
// Ports: clk_i/rst_i (async, active-high), start_i, ALUCtrl_i, data1_i, data2_i
// in; data_o, hi_o, zero_o, busy_o, done_o out (all registered).
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0110,
    OP_DIVU = 4'b1000,
    OP_MUL  = 4'b1111
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_ITER
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
`ifdef ALU_DIV_EN
  logic               div_q, div_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
`endif

  logic [WIDTH-1:0]   sc_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;

  always_comb begin
    sc_res = '0;
    case (ALUCtrl_i)
      OP_ADD:  sc_res = data1_i + data2_i;
      OP_SUB:  sc_res = data1_i - data2_i;
      OP_AND:  sc_res = data1_i & data2_i;
      OP_OR:   sc_res = data1_i | data2_i;
      OP_XOR:  sc_res = data1_i ^ data2_i;
      default: sc_res = '0;
    endcase
  end

  // acc_hi/acc_lo form one 2*WIDTH shift register shared by both iterative ops.
  // MUL: acc_lo starts as the multiplier and is shifted out LSB-first while the
  // partial product shifts in from the top. DIVU: acc_lo starts as the dividend
  // and is shifted out MSB-first while quotient bits shift in at the bottom.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + {1'b0, {WIDTH{acc_lo_q[0]}} & opnd_q};
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      if (div_shift >= {1'b0, opnd_q}) begin
        step_hi = div_diff;
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    data_d   = data_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
`ifdef ALU_DIV_EN
    div_d    = div_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            state_d  = S_ITER;
            cnt_d    = CNT_W'(WIDTH);
            acc_hi_d = '0;
            acc_lo_d = data2_i;
            opnd_d   = data1_i;
`ifdef ALU_DIV_EN
            div_d    = 1'b0;
          end else if (ALUCtrl_i == OP_DIVU) begin
            state_d  = S_ITER;
            cnt_d    = CNT_W'(WIDTH);
            acc_hi_d = '0;
            acc_lo_d = data1_i;
            opnd_d   = data2_i;
            div_d    = 1'b1;
`endif
          end else begin
            data_d = sc_res;
            hi_d   = '0;
            zero_d = (sc_res == '0);
            done_d = 1'b1;
          end
        end
      end
      S_ITER: begin
        cnt_d    = cnt_q - CNT_W'(1);
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          data_d  = step_lo;
          hi_d    = step_hi;
          zero_d  = (step_lo == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      data_q   <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef ALU_DIV_EN
      div_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      data_q   <= data_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
`ifdef ALU_DIV_EN
      div_q    <= div_d;
`endif
    end
  end

  assign data_o = data_q;
  assign hi_o   = hi_q;
  assign zero_o = zero_q;
  assign done_o = done_q;
  assign busy_o = (state_q == S_ITER);

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int unsigned W = 32;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_XOR = 4'b0011, C_SUB = 4'b0110, C_DIV = 4'b1000,
                         C_MUL = 4'b1111;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] data_o, hi_o;
  logic         zero_o, busy_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]   qop[$];
  logic [W-1:0] qa[$], qb[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .ALUCtrl_i(op),
    .data1_i  (a),
    .data2_i  (b),
    .data_o   (data_o),
    .hi_o     (hi_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result of a one-cycle opcode, straight from the opcode table.
  function automatic logic [W-1:0] ref_sc(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      C_ADD:   return x + y;
      C_SUB:   return x - y;
      C_AND:   return x & y;
      C_OR:    return x | y;
      C_XOR:   return x ^ y;
      default: return '0;
    endcase
  endfunction

  task automatic push(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    qop.push_back(o);
    qa.push_back(x);
    qb.push_back(y);
  endtask

  // Issues the queued one-cycle ops on consecutive cycles; each result must
  // appear with done_o in the cycle right after its accept edge.
  task automatic run_sc_seq(input string tag);
    logic [W-1:0] e;
    @(negedge clk);
    for (int i = 0; i < qop.size(); i++) begin
      start = 1'b1;
      op = qop[i];
      a = qa[i];
      b = qb[i];
      e = ref_sc(qop[i], qa[i], qb[i]);
      @(negedge clk);
      check({tag, " data"}, data_o, e);
      check({tag, " hi"},   hi_o, '0);
      check({tag, " zero"}, zero_o, (e == '0));
      check({tag, " done"}, done_o, 1'b1);
      check({tag, " busy"}, busy_o, 1'b0);
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, " done drop"}, done_o, 1'b0);
    qop.delete();
    qa.delete();
    qb.delete();
  endtask

  task automatic run_iter(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] elo,
                          input logic [W-1:0] ehi, input bit inject);
    int lat;
    int busy_n;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    busy_n = 0;
    while (done_o !== 1'b1 && lat < int'(W) + 8) begin
      if (busy_o === 1'b1) busy_n++;
      if (inject && lat == 9) begin
        start = 1'b1;
        op = C_ADD;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check({tag, " latency"}, lat, W);
    check({tag, " busy cycles"}, busy_n, W);
    check({tag, " busy at done"}, busy_o, 1'b0);
    check({tag, " lo"}, data_o, elo);
    check({tag, " hi"}, hi_o, ehi);
    check({tag, " zero"}, zero_o, (elo == '0));
    @(negedge clk);
    check({tag, " done pulse"}, done_o, 1'b0);
    check({tag, " lo hold"}, data_o, elo);
  endtask

  initial begin
    logic [2*W-1:0] prod;
    logic [W-1:0]   x, y;
    bit             saw_done;

    rst = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst data", data_o, '0);
    check("rst hi",   hi_o, '0);
    check("rst zero", zero_o, 1'b1);
    check("rst busy", busy_o, 1'b0);
    check("rst done", done_o, 1'b0);
    rst = 1'b0;

    push(C_ADD, 32'hFFFF_FFFF, 32'h1);
    push(C_SUB, 32'd5, 32'd7);
    push(C_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);
    push(C_AND, 32'hF0F0_F0F0, 32'h0FF0_FF00);
    push(C_OR,  32'h1234_0000, 32'h0000_5678);
    push(4'b0100, 32'hDEAD_BEEF, 32'h1);
`ifndef ALU_DIV_EN
    push(C_DIV, 32'd100, 32'd7);
`endif
    run_sc_seq("sc dir");

    for (int i = 0; i < 30; i++) begin
      logic [3:0] ops [7];
      ops = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, 4'b0101, 4'b1101};
      push(ops[$urandom_range(0, 6)], $urandom, (i % 5 == 0) ? 32'h0 : $urandom);
    end
    run_sc_seq("sc rnd");

    run_iter("mul max", C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run_iter("mul zero", C_MUL, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      run_iter("mul rnd", C_MUL, x, y, prod[W-1:0], prod[2*W-1:W], 1'b0);
    end

`ifdef ALU_DIV_EN
    run_iter("div 100/7", C_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_iter("div 9/0", C_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      run_iter("div rnd", C_DIV, x, y, x / y, x % y, 1'b0);
    end
`endif

    @(negedge clk);
    start = 1'b1;
    op = C_MUL;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst busy before", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst busy", busy_o, 1'b0);
    check("midrst data", data_o, '0);
    check("midrst hi",   hi_o, '0);
    check("midrst zero", zero_o, 1'b1);
    check("midrst done", done_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < int'(W) + 8; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    check("midrst no done", saw_done, 1'b0);
    push(C_ADD, 32'd2, 32'd3);
    run_sc_seq("post rst add");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
